// File: rtl/multi_chan_transfer_manager_pkg.sv
// Shared definitions for the multi-channel DAQ transfer manager:
// FSM state encoding, the header tag word and the DAQ header/trailer
// packing helpers (including the saturating 32-bit word counter step).
package multi_chan_transfer_manager_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HAS_FILLNUM,
        ST_HEADER1,
        ST_HEADER2,
        ST_SELECT,
        ST_SEND_COMMAND,
        ST_WAIT_RESPONSE,
        ST_READY_DATA,
        ST_DATA1,
        ST_DATA_OUT,
        ST_LAST_OUT,
        ST_TRAILER
    } state_e;

    localparam logic [31:0] HDR_TAG = 32'h00000008;

    // Word counter increment that sticks at all ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [63:0] pack_header(input logic [23:0] fill);
        return {8'h00, fill, HDR_TAG};
    endfunction

    // The trailer itself counts as one word, hence the increment.
    function automatic logic [63:0] pack_trailer(input logic [23:0] fill,
                                                 input logic [31:0] cnt);
        return {8'h00, fill, sat_inc(cnt)};
    endfunction

endpackage

// File: rtl/multi_chan_transfer_manager_chan_select.sv
// mctm_chan_select: combinational lowest-set-bit priority encoder.
// Ports:
//   mask_i  [NUM_CHAN]  remaining channel mask
//   idx_o   [CHAN_W]    index of the lowest set bit (0 when none)
//   none_o  [1]         high when the mask is all zero
module mctm_chan_select #(
    parameter int NUM_CHAN = 2,
    parameter int CHAN_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic [NUM_CHAN-1:0] mask_i,
    output logic [CHAN_W-1:0]   idx_o,
    output logic                none_o
);

    always_comb begin
        idx_o  = '0;
        none_o = (mask_i == '0);
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = CHAN_W'(i);
            end
        end
    end

endmodule

// File: rtl/multi_chan_transfer_manager.sv
// multi_chan_transfer_manager: per trigger, emits a two-word DAQ header,
// commands each enabled channel in ascending order, packs its 32-bit response
// words pairwise into 64-bit DAQ words, then emits a trailer with the fill
// number and total word count. Silent channels are abandoned after
// TIMEOUT_CYCLES and flagged in timeout_flags.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   chan_enable                   channel mask, captured on trigger accept
//   tm_fifo_*                     trigger (fill number) FIFO handshake
//   chan_tx_fifo_*                command stream to the channel links
//   chan_rx_fifo_*                response stream from the channel links
//   daq_*                         64-bit DAQ output stream
//   timeout_flags, busy           status
module multi_chan_transfer_manager
    import multi_chan_transfer_manager_pkg::*;
#(
    parameter int          NUM_CHAN       = 2,
    parameter int          CHAN_W         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
    parameter logic [31:0] CMD_WORD       = 32'hBAADF00D,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CHAN-1:0] chan_enable,
    input  logic [23:0]         tm_fifo_data,
    input  logic                tm_fifo_valid,
    output logic                tm_fifo_ready,
    output logic [31:0]         chan_tx_fifo_data,
    output logic [CHAN_W-1:0]   chan_tx_fifo_dest,
    output logic                chan_tx_fifo_valid,
    output logic                chan_tx_fifo_last,
    input  logic                chan_tx_fifo_ready,
    input  logic [31:0]         chan_rx_fifo_data,
    input  logic                chan_rx_fifo_valid,
    input  logic                chan_rx_fifo_last,
    output logic                chan_rx_fifo_ready,
    output logic [63:0]         daq_data,
    output logic                daq_valid,
    output logic                daq_header,
    output logic                daq_trailer,
    input  logic                daq_ready,
    output logic [NUM_CHAN-1:0] timeout_flags,
    output logic                busy
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [23:0]         fill_q, fill_d;
    logic [NUM_CHAN-1:0] mask_q, mask_d;
    logic [NUM_CHAN-1:0] rem_q, rem_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [63:0]         daq_data_q, daq_data_d;
    logic [NUM_CHAN-1:0] tmo_flags_q, tmo_flags_d;

    logic [CHAN_W-1:0]   sel_idx;
    logic                sel_none;

    mctm_chan_select #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) u_chan_select (
        .mask_i (rem_q),
        .idx_o  (sel_idx),
        .none_o (sel_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            mask_q      <= '0;
            rem_q       <= '0;
            word_cnt_q  <= '0;
            chan_q      <= '0;
            tmo_q       <= '0;
            daq_data_q  <= '0;
            tmo_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            mask_q      <= mask_d;
            rem_q       <= rem_d;
            word_cnt_q  <= word_cnt_d;
            chan_q      <= chan_d;
            tmo_q       <= tmo_d;
            daq_data_q  <= daq_data_d;
            tmo_flags_q <= tmo_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        mask_d      = mask_q;
        rem_d       = rem_q;
        word_cnt_d  = word_cnt_q;
        chan_d      = chan_q;
        tmo_d       = tmo_q;
        daq_data_d  = daq_data_q;
        tmo_flags_d = tmo_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (tm_fifo_valid) begin
                    fill_d      = tm_fifo_data;
                    mask_d      = chan_enable;
                    rem_d       = chan_enable;
                    word_cnt_d  = '0;
                    tmo_flags_d = '0;
                    state_d     = ST_HAS_FILLNUM;
                end
            end
            ST_HAS_FILLNUM: begin
                daq_data_d = pack_header(fill_q);
                state_d    = ST_HEADER1;
            end
            ST_HEADER1: begin
                if (daq_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    daq_data_d = 64'(mask_q);
                    state_d    = ST_HEADER2;
                end
            end
            ST_HEADER2: begin
                if (daq_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    state_d    = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_none) begin
                    daq_data_d = pack_trailer(fill_q, word_cnt_q);
                    state_d    = ST_TRAILER;
                end else begin
                    chan_d  = sel_idx;
                    rem_d   = rem_q & ~(NUM_CHAN'(1) << sel_idx);
                    state_d = ST_SEND_COMMAND;
                end
            end
            ST_SEND_COMMAND: begin
                if (chan_tx_fifo_ready) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_RESPONSE;
                end
            end
            ST_WAIT_RESPONSE: begin
                // An arriving word wins over an expiring timeout in the same cycle.
                if (chan_rx_fifo_valid) begin
                    state_d = chan_rx_fifo_last ? ST_SELECT : ST_READY_DATA;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_flags_d[chan_q] = 1'b1;
                    state_d             = ST_SELECT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_READY_DATA: begin
                if (chan_rx_fifo_valid) begin
                    daq_data_d = {chan_rx_fifo_data, 32'h0};
                    state_d    = chan_rx_fifo_last ? ST_LAST_OUT : ST_DATA1;
                end
            end
            ST_DATA1: begin
                if (chan_rx_fifo_valid) begin
                    daq_data_d = {daq_data_q[63:32], chan_rx_fifo_data};
                    state_d    = chan_rx_fifo_last ? ST_LAST_OUT : ST_DATA_OUT;
                end
            end
            ST_DATA_OUT: begin
                if (daq_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    state_d    = ST_READY_DATA;
                end
            end
            ST_LAST_OUT: begin
                if (daq_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    state_d    = ST_SELECT;
                end
            end
            ST_TRAILER: begin
                if (daq_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the registered state.
    assign tm_fifo_ready      = (state_q == ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign chan_tx_fifo_valid = (state_q == ST_SEND_COMMAND);
    assign chan_tx_fifo_last  = chan_tx_fifo_valid;
    assign chan_tx_fifo_data  = CMD_WORD;
    assign chan_tx_fifo_dest  = chan_q;
    assign chan_rx_fifo_ready = (state_q == ST_WAIT_RESPONSE) ||
                                (state_q == ST_READY_DATA)    ||
                                (state_q == ST_DATA1);
    assign daq_valid          = (state_q == ST_HEADER1)  || (state_q == ST_HEADER2) ||
                                (state_q == ST_DATA_OUT) || (state_q == ST_LAST_OUT) ||
                                (state_q == ST_TRAILER);
    assign daq_header         = (state_q == ST_HEADER1);
    assign daq_trailer        = (state_q == ST_TRAILER);
    assign daq_data           = daq_data_q;
    assign timeout_flags      = tmo_flags_q;

endmodule

// File: tb/tb_multi_chan_transfer_manager.sv
module tb_multi_chan_transfer_manager;

    localparam int NC  = 4;
    localparam int TMO = 16;
    localparam logic [31:0] CMD = 32'hBAADF00D;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] chan_enable;
    logic [23:0]   tm_fifo_data;
    logic          tm_fifo_valid;
    logic          tm_fifo_ready;
    logic [31:0]   chan_tx_fifo_data;
    logic [1:0]    chan_tx_fifo_dest;
    logic          chan_tx_fifo_valid;
    logic          chan_tx_fifo_last;
    logic          chan_tx_fifo_ready;
    logic [31:0]   chan_rx_fifo_data;
    logic          chan_rx_fifo_valid;
    logic          chan_rx_fifo_last;
    logic          chan_rx_fifo_ready;
    logic [63:0]   daq_data;
    logic          daq_valid;
    logic          daq_header;
    logic          daq_trailer;
    logic          daq_ready;
    logic [NC-1:0] timeout_flags;
    logic          busy;

    multi_chan_transfer_manager #(
        .NUM_CHAN       (NC),
        .CMD_WORD       (CMD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .chan_enable        (chan_enable),
        .tm_fifo_data       (tm_fifo_data),
        .tm_fifo_valid      (tm_fifo_valid),
        .tm_fifo_ready      (tm_fifo_ready),
        .chan_tx_fifo_data  (chan_tx_fifo_data),
        .chan_tx_fifo_dest  (chan_tx_fifo_dest),
        .chan_tx_fifo_valid (chan_tx_fifo_valid),
        .chan_tx_fifo_last  (chan_tx_fifo_last),
        .chan_tx_fifo_ready (chan_tx_fifo_ready),
        .chan_rx_fifo_data  (chan_rx_fifo_data),
        .chan_rx_fifo_valid (chan_rx_fifo_valid),
        .chan_rx_fifo_last  (chan_rx_fifo_last),
        .chan_rx_fifo_ready (chan_rx_fifo_ready),
        .daq_data           (daq_data),
        .daq_valid          (daq_valid),
        .daq_header         (daq_header),
        .daq_trailer        (daq_trailer),
        .daq_ready          (daq_ready),
        .timeout_flags      (timeout_flags),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard / reference model state
    int          checks = 0;
    int          errors = 0;
    logic [65:0] exp_q[$];      // {header, trailer, data}
    int          exp_dest_q[$];
    logic [31:0] rx_q[$];
    int          resp_len [NC]; // -1 = channel stays silent
    logic [31:0] resp_w [NC][8];
    logic [NC-1:0] exp_flags;
    logic [63:0] last_trailer;
    int          cyc = 0, acc_cyc = 0, n_daq = 0, tx_count = 0, rx_rdy_cyc = 0, stall = 0;
    bit          trig_pending = 0, lat_pending = 0, throttle = 0, hold_data = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Expected DAQ stream built directly from the framing rules.
    task automatic start_fill(input logic [23:0] fill, input logic [NC-1:0] mask);
        int cnt;
        logic [31:0] lo;
        cnt = 2;
        exp_flags = '0;
        exp_q.push_back({2'b10, 8'h00, fill, 32'h8});
        exp_q.push_back({2'b00, 60'd0, mask});
        for (int ch = 0; ch < NC; ch++) begin
            if (mask[ch]) begin
                exp_dest_q.push_back(ch);
                if (resp_len[ch] < 0) exp_flags[ch] = 1'b1;
                else for (int i = 0; i < resp_len[ch]; i += 2) begin
                    lo = (i + 1 < resp_len[ch]) ? resp_w[ch][i+1] : 32'h0;
                    exp_q.push_back({2'b00, resp_w[ch][i], lo});
                    cnt++;
                end
            end
        end
        exp_q.push_back({2'b01, 8'h00, fill, 32'(cnt + 1)});
        n_daq = 0; tx_count = 0; rx_rdy_cyc = 0;
        tm_fifo_data = fill;
        chan_enable  = mask;
        trig_pending = 1;
    endtask

    // One clock cycle: drive inputs at negedge, evaluate the handshakes that
    // will complete on the next posedge.
    task automatic tick();
        logic [65:0] e;
        @(negedge clk);
        cyc++;
        tm_fifo_valid = trig_pending;
        if (!trig_pending) begin
            tm_fifo_data = 24'($urandom());
            chan_enable  = NC'($urandom());
        end
        daq_ready = (hold_data && n_daq >= 2) ? 1'b0 : (!throttle || $urandom_range(0, 3) != 0);
        chan_tx_fifo_ready = !throttle || ($urandom_range(0, 2) != 0);
        if (rx_q.size() > 0)
            chan_rx_fifo_valid = !throttle || stall >= 3 || ($urandom_range(0, 3) != 0);
        else
            chan_rx_fifo_valid = 1'b0;
        stall = (rx_q.size() > 0 && !chan_rx_fifo_valid) ? stall + 1 : 0;
        chan_rx_fifo_data = chan_rx_fifo_valid ? rx_q[0] : $urandom();
        chan_rx_fifo_last = chan_rx_fifo_valid ? (rx_q.size() == 1) : 1'($urandom());

        if (trig_pending && tm_fifo_ready) begin
            trig_pending = 0;
            acc_cyc = cyc;
            lat_pending = 1;
        end
        if (daq_valid && lat_pending && daq_header) begin
            check("hdr_latency", 66'(cyc - acc_cyc), 66'd2);
            lat_pending = 0;
        end
        if (daq_valid && daq_ready) begin
            n_daq++;
            check("daq_expected", 66'(exp_q.size() > 0), 66'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("daq_word", {daq_header, daq_trailer, daq_data}, e);
            end
            if (daq_trailer) last_trailer = daq_data;
        end
        if (chan_tx_fifo_valid) begin
            check("tx_cmd", {33'd0, chan_tx_fifo_last, chan_tx_fifo_data}, {33'd1, CMD});
            if (chan_tx_fifo_ready) begin
                tx_count++;
                check("tx_expected", 66'(exp_dest_q.size() > 0), 66'd1);
                if (exp_dest_q.size() > 0)
                    check("tx_dest", 66'(chan_tx_fifo_dest), 66'(exp_dest_q.pop_front()));
                if (resp_len[chan_tx_fifo_dest] >= 0) begin
                    rx_q.push_back($urandom());  // response header, discarded by DUT
                    for (int i = 0; i < resp_len[chan_tx_fifo_dest]; i++)
                        rx_q.push_back(resp_w[chan_tx_fifo_dest][i]);
                end
            end
        end
        if (chan_rx_fifo_valid && chan_rx_fifo_ready) void'(rx_q.pop_front());
        if (chan_rx_fifo_ready) rx_rdy_cyc++;
    endtask

    task automatic finish_fill(input string name);
        int k = 0;
        while ((trig_pending || exp_q.size() > 0) && k < 3000) begin
            tick();
            k++;
        end
        check({name, "_done"}, 66'(k < 3000), 66'd1);
        tick();
        check({name, "_idle"}, 66'(busy), 66'd0);
        check({name, "_flags"}, 66'(timeout_flags), 66'(exp_flags));
        check({name, "_dest_left"}, 66'(exp_dest_q.size()), 66'd0);
        check({name, "_rx_left"}, 66'(rx_q.size()), 66'd0);
        $display("%s: daq_words=%0d tx=%0d flags=%b trailer=%h", name, n_daq, tx_count,
                 timeout_flags, last_trailer);
        exp_q.delete(); exp_dest_q.delete(); rx_q.delete(); trig_pending = 0;
    endtask

    task automatic rand_resp();
        for (int ch = 0; ch < NC; ch++) begin
            resp_len[ch] = ($urandom_range(0, 8) == 0) ? -1 : int'($urandom_range(0, 5));
            for (int i = 0; i < 8; i++) resp_w[ch][i] = $urandom();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1; chan_enable = '0; tm_fifo_data = '0; tm_fifo_valid = 0;
        chan_tx_fifo_ready = 0; chan_rx_fifo_data = '0; chan_rx_fifo_valid = 0;
        chan_rx_fifo_last = 0; daq_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_tm_ready", 66'(tm_fifo_ready), 66'd1);
        check("rst_busy", 66'(busy), 66'd0);
        check("rst_strobes", {60'd0, daq_valid, daq_header, daq_trailer, chan_tx_fifo_valid,
              chan_tx_fifo_last, chan_rx_fifo_ready}, 66'd0);
        check("rst_daq_data", 66'(daq_data), 66'd0);
        check("rst_flags", 66'(timeout_flags), 66'd0);
        rst = 0;

        // Directed: mask 0101, ch0 hdr+4 words, ch2 hdr+3 words
        rand_resp();
        resp_len[0] = 4; resp_len[2] = 3;
        start_fill(24'h00ABCD, 4'b0101);
        finish_fill("fill_0101");
        check("t1_trailer", 66'(last_trailer), 66'h0000ABCD_00000007);
        check("t1_tx_count", 66'(tx_count), 66'd2);
        check("t1_daq_count", 66'(n_daq), 66'd7);

        // Directed: empty mask
        start_fill(24'h123456, 4'b0000);
        finish_fill("fill_mask0");
        check("t2_trailer", 66'(last_trailer), 66'h00123456_00000003);
        check("t2_tx_count", 66'(tx_count), 66'd0);
        check("t2_daq_count", 66'(n_daq), 66'd3);

        // Directed: ch1 silent -> timeout after exactly TMO cycles in WAIT_RESPONSE
        resp_len[1] = -1;
        start_fill(24'h000777, 4'b0010);
        finish_fill("fill_timeout");
        check("t3_flags", 66'(timeout_flags), 66'b0010);
        check("t3_trailer_cnt", 66'(last_trailer[31:0]), 66'd3);
        check("t3_wait_cycles", 66'(rx_rdy_cyc), 66'(TMO));

        // Randomized fills with throttling on every interface
        throttle = 1;
        for (int f = 0; f < 1000; f++) begin
            rand_resp();
            start_fill(24'($urandom()), NC'($urandom()));
            finish_fill($sformatf("rand_fill_%0d", f));
        end

        // Reset while sitting in DATA_OUT
        throttle = 0;
        rand_resp();
        resp_len[0] = 4;
        hold_data = 1;
        start_fill(24'h0BEEF0, 4'b0001);
        k = 0;
        while (!(daq_valid && !daq_header && !daq_trailer && n_daq == 2) && k < 500) begin
            tick();
            k++;
        end
        check("rst_reach_data_out", 66'(k < 500), 66'd1);
        rst = 1;
        #1;
        check("midrst_tm_ready", 66'(tm_fifo_ready), 66'd1);
        check("midrst_busy", 66'(busy), 66'd0);
        check("midrst_strobes", {60'd0, daq_valid, daq_header, daq_trailer, chan_tx_fifo_valid,
              chan_tx_fifo_last, chan_rx_fifo_ready}, 66'd0);
        check("midrst_daq_data", 66'(daq_data), 66'd0);
        check("midrst_flags", 66'(timeout_flags), 66'd0);
        $display("reset_in_data_out: applied after %0d cycles", k);
        @(negedge clk);
        rst = 0;
        hold_data = 0;
        exp_q.delete(); exp_dest_q.delete(); rx_q.delete();
        trig_pending = 0; lat_pending = 0;
        rand_resp();
        resp_len[3] = 3;
        start_fill(24'h00C0DE, 4'b1001);
        finish_fill("fill_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_chan_transfer_manager.md
# multi_chan_transfer_manager

Parametrised successor to the two-channel DAQ transfer FSM. It moves one fill's data from the trigger FIFO, through each enabled channel link, to the 64-bit DAQ output stream. On each trigger it emits a two-word header, commands every enabled channel in ascending order, and packs that channel's 32-bit response words into 64-bit DAQ words. It then emits a trailer carrying the fill number and word count. It sits between the trigger-number FIFO, the channel TX/RX FIFO pair and the DAQ link, and adds a channel count parameter, a runtime channel mask and a per-channel response timeout.

## Interface
Parameters:
- NUM_CHAN, 2: number of channel links, 1..16.
- CHAN_W, $clog2(NUM_CHAN) min 1: channel index width.
- CMD_WORD, 32'hBAADF00D: command word sent to each channel.
- TIMEOUT_CYCLES, 1024: WAIT_RESPONSE cycles before a channel is abandoned; must be ≥2.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- chan_enable  in  NUM_CHAN  channel mask; sampled only in IDLE when a trigger is accepted.
- tm_fifo_data  in  24  fill number.
- tm_fifo_valid / tm_fifo_ready  in / out  1  trigger FIFO handshake.
- chan_tx_fifo_data  out  32  command word.
- chan_tx_fifo_dest  out  CHAN_W  target channel.
- chan_tx_fifo_valid, chan_tx_fifo_last  out  1  command strobe; last equals valid.
- chan_tx_fifo_ready  in  1  TX FIFO accept.
- chan_rx_fifo_data  in  32  response data.
- chan_rx_fifo_valid, chan_rx_fifo_last  in  1  response strobe and end of response.
- chan_rx_fifo_ready  out  1  response accept.
- daq_data  out  64  DAQ word, registered.
- daq_valid, daq_header, daq_trailer  out  1  DAQ strobes.
- daq_ready  in  1  DAQ accept.
- timeout_flags  out  NUM_CHAN  per-channel timeouts for the current or last fill; cleared on trigger accept.
- busy  out  1  high in any state other than IDLE.

## Operation
- Handshake rule: every interface transfers on the cycle where valid and ready are both high. All handshake outputs are decoded from registered state.
- IDLE: tm_fifo_ready=1. On tm_fifo_valid, latch fill_num and mask, clear word_cnt and timeout_flags, and go to HAS_FILLNUM.
- HAS_FILLNUM: load daq_data={8'h00,fill_num,32'h00000008}, then go to HEADER1.
- HEADER1: daq_valid=1, daq_header=1. On daq_ready, word_cnt++, load daq_data={{(64-NUM_CHAN){0}},mask}, go to HEADER2.
- HEADER2: daq_valid=1. On daq_ready, word_cnt++ and go to SELECT.
- SELECT: pick the lowest set bit of the remaining mask into chan_num and clear that bit, then go to SEND_COMMAND. If no bit remains, load the trailer and go to TRAILER. This state takes one cycle.
- SEND_COMMAND: drive CMD_WORD with dest=chan_num. On chan_tx_fifo_ready, load tmo_cnt=0 and go to WAIT_RESPONSE.
- WAIT_RESPONSE: rx_ready=1. The first accepted word is a response header and is discarded; go to READY_DATA. If tmo_cnt reaches TIMEOUT_CYCLES-1 with no word accepted, set timeout_flags[chan_num] and go to SELECT.
- READY_DATA: rx_ready=1. An accepted word goes into daq_data[63:32] with [31:0] zeroed. If last is set, go to LAST_OUT, which gives an odd word with zero padding; otherwise go to DATA1.
- DATA1: rx_ready=1. An accepted word goes into daq_data[31:0]. Go to LAST_OUT if last is set, else DATA_OUT.
- DATA_OUT: daq_valid=1. On daq_ready, word_cnt++ and go to READY_DATA.
- LAST_OUT: daq_valid=1. On daq_ready, word_cnt++ and go to SELECT.
- A last flag arriving in WAIT_RESPONSE ends a header-only response; go to SELECT.
- TRAILER: daq_valid=1, daq_trailer=1, daq_data={8'h00,fill_num,word_cnt+1}. word_cnt is 32-bit and saturates at all ones. On daq_ready, go to IDLE.
- All-zero mask: the output is HEADER1, HEADER2, then TRAILER with count 3.

## Timing
- Reset values: state=IDLE, so tm_fifo_ready=1 and busy=0; all other strobes 0; daq_data, fill_num, word_cnt, chan_num and timeout_flags all 0.
- Trigger accept to first header daq_valid takes 2 cycles.
- Each state that waits on a handshake holds its outputs and data stable until that handshake completes.
- Back-pressure on any interface only stalls the FSM; no data is dropped.
- tmo_cnt runs only in WAIT_RESPONSE.
- A late response from an abandoned channel stays in the RX FIFO; flushing it is the downstream's job.
- A reset asserted mid-fill aborts the fill at once with no trailer emitted.
- chan_enable and tm_fifo_data are ignored outside IDLE.

## Structure
- Shared package holds the state enum, the HDR_TAG constant 32'h00000008 and the header/trailer packing functions.
- One natural sub-module, mctm_chan_select: a combinational lowest-set-bit priority encoder producing an index and a none flag.

## Test plan
- NUM_CHAN=4, mask 4'b0101, fill 24'h00ABCD, ch0 returns hdr+4 words, ch2 returns hdr+3 words: expect dest 0 then 2, 2+2 data words (second one padded in [31:0]), and trailer {8'h00,24'h00ABCD,32'd7}.
- Mask 0: expect exactly three DAQ words with trailer count 3 and no tx_valid.
- Mask 4'b0010, ch1 silent: after TIMEOUT_CYCLES, timeout_flags=4'b0010 and trailer count 3.
- Random daq_ready/tx_ready/rx_valid throttling over 1000 fills: the DAQ word sequence must match the reference model.
- Assert rst while in DATA_OUT: outputs return to reset values in the same cycle, and the next fill starts cleanly.
